// File: rtl/midi_note_receiver.sv
`timescale 1ns/1ps
// midi_note_receiver
// Receives a serial MIDI stream, decodes bytes with a mid-bit sampling UART
// and tracks one monophonic note (last-note priority) for the sample-tick
// lookup and envelope stage. Running status and interleaved real-time bytes
// are handled.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   midi_rx        raw serial MIDI line, idle high, asynchronous to clk
//   midiNoteNumber current note (bit 7 always 0)
//   noteVelocity   velocity of the current note
//   noteGate       high while the current note is held
//   noteEvent      one-cycle pulse whenever any note output changes
//   framingError   one-cycle pulse when a stop bit samples low
module midi_note_receiver #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int MIDI_CHANNEL = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] midiNoteNumber,
  output logic [6:0] noteVelocity,
  output logic       noteGate,
  output logic       noteEvent,
  output logic       framingError
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    CHAN      = 4'(MIDI_CHANNEL % 16);
  localparam bit            OMNI      = (MIDI_CHANNEL > 15);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } uart_state_t;

  typedef enum logic [1:0] {
    RS_NONE     = 2'd0,
    RS_NOTE_OFF = 2'd1,
    RS_NOTE_ON  = 2'd2,
    RS_OTHER    = 2'd3
  } run_status_t;

  // synchroniser
  logic rx_meta_r, rx_sync_r;

  // UART
  uart_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          byte_stb_r, byte_stb_s;
  logic          fe_det_r, fe_det_s, fe_pipe_r;

  // parser
  run_status_t rs_r, rs_s;
  logic        dcnt_r, dcnt_s;
  logic [6:0]  pend_r, pend_s;
  logic        cmpl_r, cmpl_s;
  logic        cmpl_on_r, cmpl_on_s;
  logic [6:0]  cmpl_note_r, cmpl_note_s;
  logic [6:0]  cmpl_vel_r, cmpl_vel_s;

  // output stage
  logic [6:0] note_s, vel_s;
  logic       gate_s, event_s;

  // Two-flop synchroniser; resets to the idle-high level so no false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= midi_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // UART state register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      byte_stb_r <= 1'b0;
      fe_det_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      byte_stb_r <= byte_stb_s;
      fe_det_r   <= fe_det_s;
    end
  end

  // UART next-state logic; the counter saturates and reloads on state entry.
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    byte_stb_s = 1'b0;
    fe_det_s   = 1'b0;
    if (cnt_r == BIT_LAST) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    case (state_r)
      S_IDLE: begin
        if (!rx_sync_r) begin
          state_s = S_START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        // Half-bit check rejects short low glitches.
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          if (!rx_sync_r) begin
            state_s   = S_DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_s = S_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rx_sync_r) begin
            byte_stb_s = 1'b1;
            state_s    = S_IDLE;
          end else begin
            fe_det_s = 1'b1;
            state_s  = S_WAIT_HIGH;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_r) begin
          state_s = S_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_WAIT_HIGH;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Parser state register; a completed message is staged for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_r        <= RS_NONE;
      dcnt_r      <= 1'b0;
      pend_r      <= 7'd0;
      cmpl_r      <= 1'b0;
      cmpl_on_r   <= 1'b0;
      cmpl_note_r <= 7'd0;
      cmpl_vel_r  <= 7'd0;
      fe_pipe_r   <= 1'b0;
    end else begin
      rs_r        <= rs_s;
      dcnt_r      <= dcnt_s;
      pend_r      <= pend_s;
      cmpl_r      <= cmpl_s;
      cmpl_on_r   <= cmpl_on_s;
      cmpl_note_r <= cmpl_note_s;
      cmpl_vel_r  <= cmpl_vel_s;
      fe_pipe_r   <= fe_det_r;
    end
  end

  // Parser next-state: running status, data count and message completion.
  always_comb begin
    rs_s        = rs_r;
    dcnt_s      = dcnt_r;
    pend_s      = pend_r;
    cmpl_s      = 1'b0;
    cmpl_on_s   = cmpl_on_r;
    cmpl_note_s = cmpl_note_r;
    cmpl_vel_s  = cmpl_vel_r;
    if (byte_stb_r) begin
      if (shift_r[7]) begin
        if (shift_r[7:3] == 5'b11111) begin
          // real-time byte: parser untouched
          rs_s = rs_r;
        end else if (shift_r[7:4] == 4'hF) begin
          rs_s   = RS_NONE;
          dcnt_s = 1'b0;
        end else if ((shift_r[7:4] == 4'h8) && (OMNI || (shift_r[3:0] == CHAN))) begin
          rs_s   = RS_NOTE_OFF;
          dcnt_s = 1'b0;
        end else if ((shift_r[7:4] == 4'h9) && (OMNI || (shift_r[3:0] == CHAN))) begin
          rs_s   = RS_NOTE_ON;
          dcnt_s = 1'b0;
        end else begin
          rs_s   = RS_OTHER;
          dcnt_s = 1'b0;
        end
      end else begin
        if ((rs_r == RS_NOTE_ON) || (rs_r == RS_NOTE_OFF)) begin
          if (!dcnt_r) begin
            pend_s = shift_r[6:0];
            dcnt_s = 1'b1;
          end else begin
            dcnt_s      = 1'b0;
            cmpl_s      = 1'b1;
            cmpl_on_s   = (rs_r == RS_NOTE_ON) && (shift_r[6:0] != 7'd0);
            cmpl_note_s = pend_r;
            cmpl_vel_s  = shift_r[6:0];
          end
        end else begin
          dcnt_s = dcnt_r;
        end
      end
    end else begin
      rs_s = rs_r;
    end
  end

  // Note tracking: note-on always retriggers; note-off only for the held note.
  always_comb begin
    note_s  = midiNoteNumber[6:0];
    vel_s   = noteVelocity;
    gate_s  = noteGate;
    event_s = 1'b0;
    if (cmpl_r) begin
      if (cmpl_on_r) begin
        note_s  = cmpl_note_r;
        vel_s   = cmpl_vel_r;
        gate_s  = 1'b1;
        event_s = 1'b1;
      end else if (noteGate && (cmpl_note_r == midiNoteNumber[6:0])) begin
        gate_s  = 1'b0;
        event_s = 1'b1;
      end else begin
        gate_s = noteGate;
      end
    end else begin
      event_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      midiNoteNumber <= 8'h00;
      noteVelocity   <= 7'd0;
      noteGate       <= 1'b0;
      noteEvent      <= 1'b0;
      framingError   <= 1'b0;
    end else begin
      midiNoteNumber <= {1'b0, note_s};
      noteVelocity   <= vel_s;
      noteGate       <= gate_s;
      noteEvent      <= event_s;
      framingError   <= fe_pipe_r;
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
`timescale 1ns/1ps
// Testbench for midi_note_receiver: an omni instance and a channel-0 instance
// share one MIDI line and are compared against a byte-level note model.
module tb_midi_note_receiver;

  localparam int CPB = 16;
  // pin -> sync (2) + idle detect (1) + half bit + 9 bits + 2 output stages
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic midi_rx = 1'b1;
  logic [7:0] o_note[2];
  logic [6:0] o_vel[2];
  logic       o_gate[2];
  logic       o_ev[2];
  logic       o_fe[2];

  int cyc = 0;
  int ev_cnt[2] = '{0, 0};
  int fe_cnt[2] = '{0, 0};
  int last_ev_cyc[2] = '{0, 0};
  int start_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // reference model state
  int m_chan[2] = '{16, 0};
  int m_rs[2];    // 0 none, 1 other, 8 note-off, 9 note-on
  int m_dc[2];
  int m_pend[2];
  int m_note[2];
  int m_vel[2];
  int m_gate[2];
  int m_ev[2] = '{0, 0};
  int m_fe[2] = '{0, 0};

  midi_note_receiver #(.CLKS_PER_BIT(CPB), .MIDI_CHANNEL(16)) u_omni (
    .clk(clk), .reset(reset), .midi_rx(midi_rx),
    .midiNoteNumber(o_note[0]), .noteVelocity(o_vel[0]), .noteGate(o_gate[0]),
    .noteEvent(o_ev[0]), .framingError(o_fe[0])
  );

  midi_note_receiver #(.CLKS_PER_BIT(CPB), .MIDI_CHANNEL(0)) u_ch0 (
    .clk(clk), .reset(reset), .midi_rx(midi_rx),
    .midiNoteNumber(o_note[1]), .noteVelocity(o_vel[1]), .noteGate(o_gate[1]),
    .noteEvent(o_ev[1]), .framingError(o_fe[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters sampled on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (o_ev[d] === 1'b1) begin
        ev_cnt[d] <= ev_cnt[d] + 1;
        last_ev_cyc[d] <= cyc;
      end
      if (o_fe[d] === 1'b1) fe_cnt[d] <= fe_cnt[d] + 1;
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rs[d] = 0; m_dc[d] = 0; m_pend[d] = 0;
      m_note[d] = 0; m_vel[d] = 0; m_gate[d] = 0;
    end
  endtask

  task automatic model_byte(input int b);
    for (int d = 0; d < 2; d++) begin
      if (b >= 248) begin
        // real-time: nothing
      end else if (b >= 240) begin
        m_rs[d] = 0; m_dc[d] = 0;
      end else if (b >= 128) begin
        if ((b / 16 == 8 || b / 16 == 9) && (m_chan[d] == 16 || b % 16 == m_chan[d]))
          m_rs[d] = b / 16;
        else
          m_rs[d] = 1;
        m_dc[d] = 0;
      end else if (m_rs[d] >= 8) begin
        if (m_dc[d] == 0) begin
          m_pend[d] = b; m_dc[d] = 1;
        end else begin
          m_dc[d] = 0;
          if (m_rs[d] == 9 && b > 0) begin
            m_note[d] = m_pend[d]; m_vel[d] = b; m_gate[d] = 1; m_ev[d]++;
          end else if (m_gate[d] == 1 && m_pend[d] == m_note[d]) begin
            m_gate[d] = 0; m_ev[d]++;
          end
        end
      end
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    midi_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 midi_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 midi_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1 midi_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_frame(b, 1'b1);
    model_byte(int'(b));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    midi_rx = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'h00) begin n_fail++; $display("FAIL reset note[%0d]: got %h want 00", d, o_note[d]); end
      n_tests++; if (o_vel[d] !== 7'd0) begin n_fail++; $display("FAIL reset vel[%0d]: got %h want 0", d, o_vel[d]); end
      n_tests++; if (o_gate[d] !== 1'b0) begin n_fail++; $display("FAIL reset gate[%0d]: got %b want 0", d, o_gate[d]); end
      n_tests++; if (ev_cnt[d] !== 0 || fe_cnt[d] !== 0) begin n_fail++; $display("FAIL reset pulses[%0d]: ev %0d fe %0d want 0 0", d, ev_cnt[d], fe_cnt[d]); end
    end
  endtask

  task automatic test_note_on();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    n_tests++; if (last_ev_cyc[0] !== start_cyc + LAT) begin n_fail++; $display("FAIL note_on latency: event at %0d want %0d", last_ev_cyc[0], start_cyc + LAT); end
    n_tests++; if (o_note[0] !== 8'h3C || o_vel[0] !== 7'd100 || o_gate[0] !== 1'b1) begin n_fail++; $display("FAIL note_on values: got %h %0d %b want 3c 100 1", o_note[0], o_vel[0], o_gate[0]); end
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'(m_note[d])) begin n_fail++; $display("FAIL note_on note[%0d]: got %h want %h", d, o_note[d], m_note[d]); end
      n_tests++; if (o_vel[d] !== 7'(m_vel[d])) begin n_fail++; $display("FAIL note_on vel[%0d]: got %h want %h", d, o_vel[d], m_vel[d]); end
      n_tests++; if (o_gate[d] !== 1'(m_gate[d])) begin n_fail++; $display("FAIL note_on gate[%0d]: got %b want %0d", d, o_gate[d], m_gate[d]); end
      n_tests++; if (ev_cnt[d] !== m_ev[d]) begin n_fail++; $display("FAIL note_on events[%0d]: got %0d want %0d", d, ev_cnt[d], m_ev[d]); end
    end
  endtask

  task automatic test_running_status();
    send_byte(8'h40); send_byte(8'h50);
    n_tests++; if (o_note[0] !== 8'h40 || o_vel[0] !== 7'h50 || o_gate[0] !== 1'b1) begin n_fail++; $display("FAIL running values: got %h %h %b want 40 50 1", o_note[0], o_vel[0], o_gate[0]); end
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'(m_note[d]) || o_vel[d] !== 7'(m_vel[d]) || o_gate[d] !== 1'(m_gate[d])) begin n_fail++; $display("FAIL running model[%0d]: got %h %h %b want %h %h %0d", d, o_note[d], o_vel[d], o_gate[d], m_note[d], m_vel[d], m_gate[d]); end
      n_tests++; if (ev_cnt[d] !== m_ev[d]) begin n_fail++; $display("FAIL running events[%0d]: got %0d want %0d", d, ev_cnt[d], m_ev[d]); end
    end
  endtask

  task automatic test_note_off();
    int ev_before;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    ev_before = ev_cnt[0];
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
    n_tests++; if (o_gate[0] !== 1'b1 || ev_cnt[0] !== ev_before) begin n_fail++; $display("FAIL off_nomatch: gate %b events +%0d want 1 +0", o_gate[0], ev_cnt[0] - ev_before); end
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h00);
    n_tests++; if (o_gate[0] !== 1'b0 || o_note[0] !== 8'h3C || ev_cnt[0] !== ev_before + 1) begin n_fail++; $display("FAIL off_match: gate %b note %h events +%0d want 0 3c +1", o_gate[0], o_note[0], ev_cnt[0] - ev_before); end
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'(m_note[d]) || o_vel[d] !== 7'(m_vel[d]) || o_gate[d] !== 1'(m_gate[d])) begin n_fail++; $display("FAIL note_off model[%0d]: got %h %h %b want %h %h %0d", d, o_note[d], o_vel[d], o_gate[d], m_note[d], m_vel[d], m_gate[d]); end
      n_tests++; if (ev_cnt[d] !== m_ev[d]) begin n_fail++; $display("FAIL note_off events[%0d]: got %0d want %0d", d, ev_cnt[d], m_ev[d]); end
    end
  endtask

  task automatic test_realtime();
    int ev_before;
    ev_before = ev_cnt[0];
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h64);
    n_tests++; if (o_note[0] !== 8'h3C || o_vel[0] !== 7'h64 || o_gate[0] !== 1'b1 || ev_cnt[0] !== ev_before + 1) begin n_fail++; $display("FAIL realtime: got %h %h %b +%0d want 3c 64 1 +1", o_note[0], o_vel[0], o_gate[0], ev_cnt[0] - ev_before); end
    n_tests++; if (ev_cnt[1] !== m_ev[1] || o_gate[1] !== 1'(m_gate[1])) begin n_fail++; $display("FAIL realtime ch0: events %0d gate %b want %0d %0d", ev_cnt[1], o_gate[1], m_ev[1], m_gate[1]); end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1 midi_rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    #1 midi_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (ev_cnt[d] !== m_ev[d] || fe_cnt[d] !== m_fe[d]) begin n_fail++; $display("FAIL glitch pulses[%0d]: ev %0d fe %0d want %0d %0d", d, ev_cnt[d], fe_cnt[d], m_ev[d], m_fe[d]); end
      n_tests++; if (o_note[d] !== 8'(m_note[d]) || o_gate[d] !== 1'(m_gate[d])) begin n_fail++; $display("FAIL glitch outputs[%0d]: got %h %b want %h %0d", d, o_note[d], o_gate[d], m_note[d], m_gate[d]); end
    end
  endtask

  task automatic test_framing();
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (CPB) @(posedge clk);
    drive_frame(8'h90, 1'b0);
    m_fe[0]++; m_fe[1]++;
    repeat (2 * CPB) @(posedge clk);
    send_byte(8'h3C); send_byte(8'h64);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (fe_cnt[d] !== m_fe[d]) begin n_fail++; $display("FAIL framing count[%0d]: got %0d want %0d", d, fe_cnt[d], m_fe[d]); end
      n_tests++; if (ev_cnt[d] !== m_ev[d] || o_gate[d] !== 1'b0 || o_note[d] !== 8'h00) begin n_fail++; $display("FAIL framing ignored[%0d]: ev %0d gate %b note %h want %0d 0 00", d, ev_cnt[d], o_gate[d], o_note[d], m_ev[d]); end
    end
  endtask

  task automatic test_channel();
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
    n_tests++; if (o_note[1] !== 8'h00 || o_gate[1] !== 1'b0 || ev_cnt[1] !== m_ev[1]) begin n_fail++; $display("FAIL channel reject: note %h gate %b ev %0d want 00 0 %0d", o_note[1], o_gate[1], ev_cnt[1], m_ev[1]); end
    n_tests++; if (o_note[0] !== 8'h3C || o_gate[0] !== 1'b1 || ev_cnt[0] !== m_ev[0]) begin n_fail++; $display("FAIL channel omni: note %h gate %b ev %0d want 3c 1 %0d", o_note[0], o_gate[0], ev_cnt[0], m_ev[0]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1 midi_rx = 1'b0;
    repeat (3 * CPB + 5) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'h00 || o_vel[d] !== 7'd0 || o_gate[d] !== 1'b0 || o_ev[d] !== 1'b0 || o_fe[d] !== 1'b0) begin n_fail++; $display("FAIL reset_mid async[%0d]: %h %h %b %b %b want all 0", d, o_note[d], o_vel[d], o_gate[d], o_ev[d], o_fe[d]); end
    end
    midi_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (CPB) @(posedge clk);
    send_byte(8'h3C); send_byte(8'h64);
    n_tests++; if (o_gate[0] !== 1'b0 || ev_cnt[0] !== m_ev[0]) begin n_fail++; $display("FAIL reset_mid data ignored: gate %b ev %0d want 0 %0d", o_gate[0], ev_cnt[0], m_ev[0]); end
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (o_note[d] !== 8'h3C || o_vel[d] !== 7'h64 || o_gate[d] !== 1'b1 || ev_cnt[d] !== m_ev[d]) begin n_fail++; $display("FAIL reset_mid recv[%0d]: %h %h %b ev %0d want 3c 64 1 %0d", d, o_note[d], o_vel[d], o_gate[d], ev_cnt[d], m_ev[d]); end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 1) b = 8'(($urandom_range(8, 9) << 4) | $urandom_range(0, 1));
      else if (r == 2) b = 8'(248 + $urandom_range(0, 7));
      else if (r == 3) b = 8'(240 + $urandom_range(0, 7));
      else if (r == 4) b = 8'(160 + $urandom_range(0, 79));
      else if ($urandom_range(0, 4) == 0) b = 8'h00;
      else b = 8'(60 + $urandom_range(0, 3));
      send_byte(b);
      for (int d = 0; d < 2; d++) begin
        n_tests++; if (o_note[d] !== 8'(m_note[d]) || o_vel[d] !== 7'(m_vel[d]) || o_gate[d] !== 1'(m_gate[d])) begin n_fail++; $display("FAIL random[%0d] byte %h dut %0d: got %h %h %b want %h %h %0d", n, b, d, o_note[d], o_vel[d], o_gate[d], m_note[d], m_vel[d], m_gate[d]); end
        n_tests++; if (ev_cnt[d] !== m_ev[d]) begin n_fail++; $display("FAIL random[%0d] events dut %0d: got %0d want %0d", n, d, ev_cnt[d], m_ev[d]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_note_off();
    test_realtime();
    test_glitch();
    test_framing();
    test_channel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_note_receiver.md
# midi_note_receiver

Receives the serial MIDI stream from the opto-isolated input pin and tracks a single monophonic note. It presents the current note number, velocity and gate to the note-number-to-sample-ticks lookup and the envelope stage. The block contains a 31250-baud UART receiver and a MIDI message parser. It handles running status and interleaved real-time bytes, and uses last-note priority.

## Interface
- CLKS_PER_BIT, 1600, clk cycles per MIDI bit (50 MHz / 31250 baud); must be ≥ 8.
- MIDI_CHANNEL, 16, channel 0–15 to accept; 16 means omni (all channels accepted).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- midi_rx  input  1  raw serial MIDI line; idle high; asynchronous to clk.
- midiNoteNumber  output  8  current note, bit 7 always 0; drives the lookup's midiNoteNumber input.
- noteVelocity  output  7  velocity of the current note.
- noteGate  output  1  high while the current note is held.
- noteEvent  output  1  one-cycle pulse whenever any of midiNoteNumber, noteVelocity or noteGate changes.
- framingError  output  1  one-cycle pulse when a byte's stop bit samples low.

## Operation
- **Reset values:** all outputs 0; UART in IDLE; running status NONE; data count 0.
- **Input synchroniser:** midi_rx passes through a 2-flop synchroniser; all logic uses the synchronised signal.
- **UART states:**
  - IDLE: wait for the synchronised line to be low.
  - START: count to CLKS_PER_BIT/2−1. If the line is still low, go to DATA; if high, treat as a glitch and return to IDLE with no output.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample once, CLKS_PER_BIT cycles after the last data bit.
    - High: assert an internal byte strobe for 1 cycle and go to IDLE.
    - Low: pulse framingError, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE once the line is high.
- **Bit counter:** width is clog2(CLKS_PER_BIT). It reloads on every state entry and counts with no overflow.
- **Parser**, on each byte strobe:
  - 0xF8–0xFF (real-time): ignore; parser state is untouched.
  - 0xF0–0xF7: running status becomes NONE; data count becomes 0.
  - 0x8n or 0x9n with the channel accepted: running status becomes NOTE_OFF or NOTE_ON respectively; data count becomes 0.
  - Any other status byte, including note status on a rejected channel: running status becomes OTHER; data count becomes 0.
  - Data byte with running status NONE or OTHER: ignore.
  - Data byte with running status NOTE_OFF or NOTE_ON:
    - Data count 0: latch it as the pending note; data count becomes 1.
    - Data count 1: complete the message; data count returns to 0 and running status is retained.
- **Completed NOTE_ON, velocity > 0:**
  - midiNoteNumber ← pending note; noteVelocity ← velocity; noteGate ← 1; pulse noteEvent.
  - This applies even when the gate is already high (legato retrigger).
- **Completed NOTE_OFF (any velocity), or NOTE_ON with velocity 0:**
  - If noteGate=1 and the pending note equals midiNoteNumber: noteGate ← 0 and pulse noteEvent. midiNoteNumber and noteVelocity hold their values.
  - Otherwise: no change and no pulse.
- **Outputs:** all are registered and change only together with a noteEvent pulse.

## Timing
- **Pin to synchronised line:** 2 cycles.
- **Stop-bit sample edge E:**
  - The byte strobe is high during the cycle after E.
  - Output updates, noteEvent and framingError are visible after edge E+2 and last exactly 1 cycle.
- **Bit window:** a byte occupies 10·CLKS_PER_BIT cycles from the start-bit falling edge. Back-to-back bytes with no idle gap must be received: IDLE is re-entered before the next start edge, because the stop sample is taken at mid-bit.
- **Simultaneous events:** at most one byte strobe per byte time, so no two parser events can collide.
- **Reset mid-byte:** the partial byte is lost. After release, a full start edge is required, and running status is NONE, so a data byte after reset is ignored.
- **Line held low after reset (break):** WAIT_HIGH semantics apply only after a framing error. After reset the block enters IDLE and interprets the low line as a start bit.

## Test plan
- **Note on, omni:** bytes 0x90 0x3C 0x64 at 31250 baud -> midiNoteNumber=0x3C, noteVelocity=100, noteGate=1, exactly one noteEvent, 2 cycles after the final stop sample.
- **Running status:** 0x90 0x3C 0x64 0x40 0x50 -> two noteEvents; final midiNoteNumber=0x40, noteVelocity=0x50, noteGate=1.
- **Note off matching:**
  - After note on 0x3C, send 0x80 0x40 0x00 -> noteGate stays 1, no noteEvent.
  - Then send 0x90 0x3C 0x00 -> noteGate=0, one noteEvent, midiNoteNumber stays 0x3C.
- **Real-time interleave:** 0x90 0xF8 0x3C 0xFE 0x64 -> single noteEvent with note 0x3C, velocity 0x64.
- **Line errors:**
  - 0.3-bit low glitch -> no byte, no outputs.
  - Byte 0x90 with stop bit driven low -> one framingError pulse; then 0x3C 0x64 are ignored (running status NONE).
- **Channel filter and reset:**
  - With MIDI_CHANNEL=0, send 0x91 0x3C 0x64 -> no change.
  - Assert reset mid-byte -> all outputs 0 immediately; next valid 0x90 0x3C 0x64 is received correctly.
